// File: rtl/led_seq_pkg.sv
// Shared types for the LED sequencer: command opcodes, display modes and FSM states.
package led_seq_pkg;

  typedef enum logic [1:0] {
    OP_STOP       = 2'd0,
    OP_START      = 2'd1,
    OP_SET_PERIOD = 2'd2,
    OP_SET_MODE   = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    MODE_ROT_L  = 2'd0,
    MODE_ROT_R  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } led_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_seq_prescaler.sv
// Step-rate prescaler: counts 0..P-1 while enabled and pulses tick on the wrap cycle.
module led_seq_prescaler #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] last;

  // Period 0 behaves like period 1: step on every cycle.
  assign last = (period == '0) ? '0 : period - CNT_W'(1);
  assign tick = en && (count_q == last);

  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      count_q <= '0;
    end else if (tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// Command-driven LED bank sequencer: run/idle FSM, one-entry config slot and
// pattern/direction/blink-phase registers stepped by the prescaler tick.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int          LED_W      = 16,
  parameter int          CNT_W      = 32,
  parameter int unsigned DEF_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_data,
  output logic [LED_W-1:0] led,
  output logic             busy,
  output logic             tick,
  output seq_state_e       dbg_state
);

  // Command handshake: a command transfers on a rising edge where
  // cmd_valid && cmd_ready; cmd_ready drops only while the config slot is full.

  seq_state_e       state_q, state_d;
  led_mode_e        mode_q, mode_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [LED_W-1:0] pat_q, pat_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             dir_q, dir_d;
  logic             phase_q, phase_d;
  logic             pend_valid_q, pend_valid_d;
  cmd_op_e          pend_op_q, pend_op_d;
  logic [31:0]      pend_data_q, pend_data_d;

  logic             accept;
  logic             clr;
  cmd_op_e          op;

  assign op        = cmd_op_e'(cmd_op);
  assign cmd_ready = !pend_valid_q;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q == ST_RUN);
  assign led       = led_q;
  assign dbg_state = state_q;

  led_seq_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q == ST_RUN),
    .clr    (clr),
    .period (period_q),
    .tick   (tick)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    period_d     = period_q;
    pat_d        = pat_q;
    dir_d        = dir_q;
    phase_d      = phase_q;
    pend_valid_d = pend_valid_q;
    pend_op_d    = pend_op_q;
    pend_data_d  = pend_data_q;
    clr          = 1'b0;

    // The step on a tick edge always uses the mode in force before that edge.
    if (tick) begin
      case (mode_q)
        MODE_ROT_L: pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
        MODE_ROT_R: pat_d = {pat_q[0], pat_q[LED_W-1:1]};
        MODE_BOUNCE: begin
          if (dir_q == DIR_LEFT) begin
            if (pat_q[LED_W-1]) begin
              dir_d = DIR_RIGHT;
              pat_d = {1'b0, pat_q[LED_W-1:1]};
            end else begin
              pat_d = {pat_q[LED_W-2:0], 1'b0};
            end
          end else begin
            if (pat_q[0]) begin
              dir_d = DIR_LEFT;
              pat_d = {pat_q[LED_W-2:0], 1'b0};
            end else begin
              pat_d = {1'b0, pat_q[LED_W-1:1]};
            end
          end
        end
        default: phase_d = !phase_q;
      endcase
    end

    // Pending config lands one edge after acceptance in IDLE, on the next tick in RUN.
    if (pend_valid_q && ((state_q == ST_IDLE) || tick)) begin
      pend_valid_d = 1'b0;
      if (pend_op_q == OP_SET_PERIOD) begin
        period_d = pend_data_q[CNT_W-1:0];
      end else if (pend_op_q == OP_SET_MODE) begin
        mode_d  = led_mode_e'(pend_data_q[1:0]);
        dir_d   = DIR_LEFT;
        phase_d = 1'b0;
        if (pend_data_q[2]) begin
          pat_d = pend_data_q[16 +: LED_W];
        end
      end
    end

    if (accept) begin
      case (op)
        OP_STOP: begin
          state_d = ST_IDLE;
          phase_d = 1'b0;
          clr     = 1'b1;
        end
        OP_START: begin
          if (state_q == ST_IDLE) begin
            state_d = ST_RUN;
            clr     = 1'b1;
          end
        end
        default: begin
          pend_valid_d = 1'b1;
          pend_op_d    = op;
          pend_data_d  = cmd_data;
        end
      endcase
    end

    led_d = phase_d ? '0 : pat_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_ROT_L;
      period_q     <= CNT_W'(DEF_PERIOD);
      pat_q        <= LED_W'(1);
      led_q        <= LED_W'(1);
      dir_q        <= DIR_LEFT;
      phase_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_op_q    <= OP_STOP;
      pend_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      period_q     <= period_d;
      pat_q        <= pat_d;
      led_q        <= led_d;
      dir_q        <= dir_d;
      phase_q      <= phase_d;
      pend_valid_q <= pend_valid_d;
      pend_op_q    <= pend_op_d;
      pend_data_q  <= pend_data_d;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed self-checking bench for led_seq_ctrl: rotate, bounce, pending config,
// blink/stop, period-0 stepping and reset in the middle of a run.
module tb_led_seq_ctrl;
  import led_seq_pkg::*;

  localparam int LED_W = 16;
  localparam int CNT_W = 32;
  localparam int DEF_P = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [31:0]      cmd_data;
  logic [LED_W-1:0] led;
  logic             busy;
  logic             tick;
  seq_state_e       dbg_state;

  int errors = 0;
  int checks = 0;
  logic [LED_W-1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  led_seq_ctrl #(
    .LED_W      (LED_W),
    .CNT_W      (CNT_W),
    .DEF_PERIOD (DEF_P)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .led       (led),
    .busy      (busy),
    .tick      (tick),
    .dbg_state (dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // driver: present one command and hold it for exactly one accepting edge
  task automatic do_cmd(input logic [1:0] op, input logic [31:0] data);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      step(1);
      n++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step(1);
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_data  = '0;
  endtask

  // Returns the number of edges up to and including the next stepping edge.
  task automatic wait_tick(output int cycles);
    cycles = 0;
    while (!tick && cycles < 100) begin
      step(1);
      cycles++;
    end
    if (!tick) check("tick_timeout", 32'(tick), 32'd1);
    else begin
      step(1);
      cycles++;
    end
  endtask

  initial begin
    int   c;
    logic tick_seen;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_data  = '0;
    step(2);
    rst = 1'b0;

    // reset and idle
    tick_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick_seen |= tick;
      step(1);
    end
    check("reset_led", 32'(led), 32'h0001);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(cmd_ready), 32'd1);
    check("reset_no_tick", 32'(tick_seen), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));

    // rotate left at period 4, full lap
    do_cmd(OP_SET_PERIOD, 32'd4);
    do_cmd(OP_START, 32'd0);
    check("rot_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 16; k++) exp_q.push_back(LED_W'(32'd1 << (k % 16)));
    for (int k = 0; k < 16; k++) begin
      wait_tick(c);
      check("rot_spacing", 32'(c), 32'd4);
      check("rot_led", 32'(led), 32'(exp_q.pop_front()));
    end
    do_cmd(OP_STOP, 32'd0);
    check("rot_stop_busy", 32'(busy), 32'd0);
    check("rot_stop_led", 32'(led), 32'h0001);

    // bounce from the top bit down to bit 0 and back
    do_cmd(OP_SET_MODE, 32'h8000_0006);
    step(1);
    check("bnc_load", 32'(led), 32'h8000);
    do_cmd(OP_START, 32'd0);
    for (int k = 1; k <= 15; k++) exp_q.push_back(LED_W'(32'h8000 >> k));
    exp_q.push_back(16'h0002);
    for (int k = 0; k < 16; k++) begin
      wait_tick(c);
      check("bnc_led", 32'(led), 32'(exp_q.pop_front()));
    end
    do_cmd(OP_STOP, 32'd0);

    // pending SET_PERIOD in RUN takes effect on the next tick
    do_cmd(OP_SET_MODE, 32'h0001_0004);
    do_cmd(OP_START, 32'd0);
    wait_tick(c);
    check("pend_first_spacing", 32'(c), 32'd4);
    check("pend_first_led", 32'(led), 32'h0002);
    do_cmd(OP_SET_PERIOD, 32'd8);
    check("pend_ready_low", 32'(cmd_ready), 32'd0);
    wait_tick(c);
    check("pend_apply_spacing", 32'(c), 32'd3);
    check("pend_apply_led", 32'(led), 32'h0004);
    check("pend_ready_back", 32'(cmd_ready), 32'd1);
    wait_tick(c);
    check("pend_new_spacing1", 32'(c), 32'd8);
    check("pend_new_led1", 32'(led), 32'h0008);
    wait_tick(c);
    check("pend_new_spacing2", 32'(c), 32'd8);
    check("pend_new_led2", 32'(led), 32'h0010);
    do_cmd(OP_STOP, 32'd0);
    check("pend_stop_led", 32'(led), 32'h0010);

    // blink at period 2, stop while dark
    do_cmd(OP_SET_PERIOD, 32'd2);
    do_cmd(OP_SET_MODE, 32'h00FF_0007);
    step(1);
    check("blink_load", 32'(led), 32'h00FF);
    do_cmd(OP_START, 32'd0);
    wait_tick(c);
    check("blink_spacing", 32'(c), 32'd2);
    check("blink_off1", 32'(led), 32'h0000);
    wait_tick(c);
    check("blink_on", 32'(led), 32'h00FF);
    wait_tick(c);
    check("blink_off2", 32'(led), 32'h0000);
    do_cmd(OP_STOP, 32'd0);
    check("blink_stop_led", 32'(led), 32'h00FF);
    check("blink_stop_busy", 32'(busy), 32'd0);
    step(3);
    check("blink_idle_hold", 32'(led), 32'h00FF);

    // period 0 steps every cycle; STOP on a tick edge still steps
    do_cmd(OP_SET_PERIOD, 32'd0);
    do_cmd(OP_SET_MODE, 32'h0001_0004);
    do_cmd(OP_START, 32'd0);
    wait_tick(c);
    check("p0_spacing1", 32'(c), 32'd1);
    check("p0_led1", 32'(led), 32'h0002);
    wait_tick(c);
    check("p0_spacing2", 32'(c), 32'd1);
    check("p0_led2", 32'(led), 32'h0004);
    check("p0_tick_held", 32'(tick), 32'd1);
    do_cmd(OP_STOP, 32'd0);
    check("p0_stop_step_led", 32'(led), 32'h0008);
    check("p0_stop_busy", 32'(busy), 32'd0);

    // reset mid-run with a pending SET_MODE
    do_cmd(OP_SET_PERIOD, 32'd4);
    do_cmd(OP_SET_MODE, 32'h0001_0004);
    do_cmd(OP_START, 32'd0);
    wait_tick(c);
    check("rmr_led_before", 32'(led), 32'h0002);
    do_cmd(OP_SET_MODE, 32'h8000_0007);
    check("rmr_pending", 32'(cmd_ready), 32'd0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rmr_led", 32'(led), 32'h0001);
    check("rmr_busy", 32'(busy), 32'd0);
    check("rmr_ready", 32'(cmd_ready), 32'd1);
    check("rmr_tick", 32'(tick), 32'd0);
    do_cmd(OP_START, 32'd0);
    wait_tick(c);
    check("rmr_def_period", 32'(c), 32'(DEF_P));
    check("rmr_mode_rotl", 32'(led), 32'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
